// File: rtl/decode_stage.sv
// RV32I decode stage: fetch handshake, register-file read, field/immediate decode, and a
// registered decode packet whose operands track writebacks while the packet is stalled.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic [4:0]      rf_rs1_addr_o,
  output logic [4:0]      rf_rs2_addr_o,
  output logic            rf_re_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_rs1_o,
  output logic [XLEN-1:0] id_rs2_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [4:0]      id_rd_addr_o,
  output logic            id_we_rd_o,
  output logic [3:0]      id_op_o,
  output logic [2:0]      id_funct3_o,
  output logic            id_funct7b5_o,
  output logic            id_illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OPIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_FENCE  = 4'd9;
  localparam logic [3:0] CLS_SYSTEM = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic            w_adv;
  logic            w_accept;
  logic            w_stall;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_s;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm_u;
  logic [31:0]     w_imm_j;
  logic [3:0]      w_cls;
  logic [XLEN-1:0] w_imm;
  logic            w_known;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_wr;
  logic            w_bad_fn;
  logic            w_illegal;
  logic            w_we_rd;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic            r_we_rd;
  logic [3:0]      r_op;
  logic [2:0]      r_f3;
  logic            r_f7b5;
  logic            r_illegal;
  logic [1:0][4:0]      r_rs_addr;
  logic [1:0][XLEN-1:0] w_rf_data;
  logic [1:0][XLEN-1:0] w_rs_out;

  assign w_adv         = ~r_valid | id_ready_i;
  assign instr_ready_o = w_adv & ~flush_i;
  assign rf_re_o       = w_adv | flush_i;
  assign w_accept      = instr_valid_i & instr_ready_o;
  assign w_stall       = r_valid & ~id_ready_i;

  assign w_opc = instr_i[6:0];
  assign w_f3  = instr_i[14:12];
  assign w_f7  = instr_i[31:25];
  assign w_rd  = instr_i[11:7];

  assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_u = {instr_i[31:12], 12'b0};
  assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    w_cls     = CLS_ILL;
    w_known   = 1'b1;
    w_imm     = '0;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    w_wr      = 1'b0;
    w_bad_fn  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_cls     = CLS_OP;
        w_use_rs2 = 1'b1;
        w_wr      = 1'b1;
        w_bad_fn  = ((w_f7 != F7_ZERO) && (w_f7 != F7_ALT)) ||
                    ((w_f7 == F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      OPC_OPIMM: begin
        w_cls    = CLS_OPIMM;
        w_imm    = w_imm_i;
        w_wr     = 1'b1;
        w_bad_fn = ((w_f3 == 3'b001) && (w_f7 != F7_ZERO)) ||
                   ((w_f3 == 3'b101) && (w_f7 != F7_ZERO) && (w_f7 != F7_ALT));
      end
      OPC_LOAD: begin
        w_cls = CLS_LOAD;
        w_imm = w_imm_i;
        w_wr  = 1'b1;
      end
      OPC_STORE: begin
        w_cls     = CLS_STORE;
        w_imm     = w_imm_s;
        w_use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        w_cls     = CLS_BRANCH;
        w_imm     = w_imm_b;
        w_use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        w_cls     = CLS_JAL;
        w_imm     = w_imm_j;
        w_use_rs1 = 1'b0;
        w_wr      = 1'b1;
      end
      OPC_JALR: begin
        w_cls = CLS_JALR;
        w_imm = w_imm_i;
        w_wr  = 1'b1;
      end
      OPC_LUI: begin
        w_cls     = CLS_LUI;
        w_imm     = w_imm_u;
        w_use_rs1 = 1'b0;
        w_wr      = 1'b1;
      end
      OPC_AUIPC: begin
        w_cls     = CLS_AUIPC;
        w_imm     = w_imm_u;
        w_use_rs1 = 1'b0;
        w_wr      = 1'b1;
      end
      OPC_FENCE: begin
        w_cls = CLS_FENCE;
      end
      OPC_SYSTEM: begin
        w_cls = CLS_SYSTEM;
        w_imm = w_imm_i;
        w_wr  = 1'b1;
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  assign w_illegal = (instr_i[1:0] != 2'b11) | ~w_known | w_bad_fn;
  assign w_we_rd   = w_wr & ~w_illegal & (w_rd != 5'd0);

  // Register-file ports are addressed straight from the fetched word so data lands with the packet.
  assign rf_rs1_addr_o = w_use_rs1 ? instr_i[19:15] : 5'd0;
  assign rf_rs2_addr_o = w_use_rs2 ? instr_i[24:20] : 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_we_rd   <= 1'b0;
      r_op      <= '0;
      r_f3      <= '0;
      r_f7b5    <= 1'b0;
      r_illegal <= 1'b0;
      r_rs_addr <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_accept;
      end
      if (w_accept) begin
        r_pc         <= pc_i;
        r_imm        <= w_imm;
        r_rd         <= w_rd;
        r_we_rd      <= w_we_rd;
        r_op         <= w_illegal ? CLS_ILL : w_cls;
        r_f3         <= w_f3;
        r_f7b5       <= instr_i[30];
        r_illegal    <= w_illegal;
        r_rs_addr[0] <= rf_rs1_addr_o;
        r_rs_addr[1] <= rf_rs2_addr_o;
      end
    end
  end

  assign w_rf_data[0] = rf_rs1_data_i;
  assign w_rf_data[1] = rf_rs2_data_i;

  // Per-operand snoop: the RF holds its output during a stall, so writebacks to the
  // packet's sources are captured here instead. Flags drop whenever the packet moves on.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_snoop
      logic            r_ov_flag;
      logic [XLEN-1:0] r_ov_data;
      logic            w_hit;

      assign w_hit = w_stall & wb_we_i & (r_rs_addr[gi] != 5'd0) & (wb_rd_addr_i == r_rs_addr[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ov_flag <= 1'b0;
          r_ov_data <= '0;
        end else if (flush_i | w_adv) begin
          r_ov_flag <= 1'b0;
        end else if (w_hit) begin
          r_ov_flag <= 1'b1;
          r_ov_data <= wb_data_i;
        end
      end

      assign w_rs_out[gi] = r_ov_flag ? r_ov_data : w_rf_data[gi];
    end
  endgenerate

  assign id_valid_o    = r_valid;
  assign id_pc_o       = r_pc;
  assign id_rs1_o      = w_rs_out[0];
  assign id_rs2_o      = w_rs_out[1];
  assign id_imm_o      = r_imm;
  assign id_rd_addr_o  = r_rd;
  assign id_we_rd_o    = r_we_rd;
  assign id_op_o       = r_op;
  assign id_funct3_o   = r_f3;
  assign id_funct7b5_o = r_f7b5;
  assign id_illegal_o  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small registered register-file model
// (read enable, write-through bypass, async-reset outputs).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [4:0]  rf_rs1_addr_o;
  logic [4:0]  rf_rs2_addr_o;
  logic        rf_re_o;
  logic [31:0] rf_rs1_data_i;
  logic [31:0] rf_rs2_data_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_rs1_o;
  logic [31:0] id_rs2_o;
  logic [31:0] id_imm_o;
  logic [4:0]  id_rd_addr_o;
  logic        id_we_rd_o;
  logic [3:0]  id_op_o;
  logic [2:0]  id_funct3_o;
  logic        id_funct7b5_o;
  logic        id_illegal_o;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD   = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] I_SW    = 32'hFE512E23; // sw   x5,-4(x2)
  localparam logic [31:0] I_ADD35 = 32'h005101B3; // add  x3,x2,x5
  localparam logic [31:0] I_ADD22 = 32'h002101B3; // add  x3,x2,x2
  localparam logic [31:0] I_MUL   = 32'h023100B3; // funct7=0000001
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui  x7,0x12345

  decode_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .rf_rs1_addr_o (rf_rs1_addr_o),
    .rf_rs2_addr_o (rf_rs2_addr_o),
    .rf_re_o       (rf_re_o),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_data_i     (wb_data_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_rs1_o      (id_rs1_o),
    .id_rs2_o      (id_rs2_o),
    .id_imm_o      (id_imm_o),
    .id_rd_addr_o  (id_rd_addr_o),
    .id_we_rd_o    (id_we_rd_o),
    .id_op_o       (id_op_o),
    .id_funct3_o   (id_funct3_o),
    .id_funct7b5_o (id_funct7b5_o),
    .id_illegal_o  (id_illegal_o)
  );

  always #5 clk = ~clk;

  // Register-file model
  logic [31:0] rf_mem [32];

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we_i && wb_rd_addr_i == a) return wb_data_i;
    return rf_mem[a];
  endfunction

  always @(posedge clk) begin
    if (wb_we_i && wb_rd_addr_i != 5'd0) rf_mem[wb_rd_addr_i] <= wb_data_i;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rs1_data_i <= 32'h0;
      rf_rs2_data_i <= 32'h0;
    end else if (rf_re_o) begin
      rf_rs1_data_i <= rf_read(rf_rs1_addr_o);
      rf_rs2_data_i <= rf_read(rf_rs2_addr_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1;
    wb_rd_addr_i = a;
    wb_data_i = d;
    step();
    wb_we_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst = 1'b1;
    instr_valid_i = 1'b0;
    instr_i = 32'h0;
    pc_i = 32'h0;
    flush_i = 1'b0;
    wb_we_i = 1'b0;
    wb_rd_addr_i = 5'd0;
    wb_data_i = 32'h0;
    id_ready_i = 1'b1;
    step();
    step();
    check("rst_valid", {31'b0, id_valid_o}, 32'd0);
    check("rst_illegal", {31'b0, id_illegal_o}, 32'd0);
    check("rst_we", {31'b0, id_we_rd_o}, 32'd0);
    check("rst_op", {28'b0, id_op_o}, 32'd0);
    check("rst_rs1", id_rs1_o, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, instr_ready_o}, 32'd1);
    check("post_rst_re", {31'b0, rf_re_o}, 32'd1);

    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    wb_write(5'd5, 32'h55);

    // Back-to-back stream
    instr_valid_i = 1'b1; instr_i = I_ADDI; pc_i = 32'h100; id_ready_i = 1'b1;
    #1;
    check("addi_rs1a", {27'b0, rf_rs1_addr_o}, 32'd0);
    step();
    check("addi_valid", {31'b0, id_valid_o}, 32'd1);
    check("addi_op", {28'b0, id_op_o}, 32'd1);
    check("addi_imm", id_imm_o, 32'd5);
    check("addi_rd", {27'b0, id_rd_addr_o}, 32'd1);
    check("addi_we", {31'b0, id_we_rd_o}, 32'd1);
    check("addi_pc", id_pc_o, 32'h100);
    instr_i = I_ADD; pc_i = 32'h104;
    #1;
    check("add_rs1a", {27'b0, rf_rs1_addr_o}, 32'd1);
    check("add_rs2a", {27'b0, rf_rs2_addr_o}, 32'd1);
    step();
    check("add_valid", {31'b0, id_valid_o}, 32'd1);
    check("add_op", {28'b0, id_op_o}, 32'd0);
    check("add_rd", {27'b0, id_rd_addr_o}, 32'd2);
    check("add_rs1", id_rs1_o, 32'h11);
    check("add_rs2", id_rs2_o, 32'h11);
    check("add_pc", id_pc_o, 32'h104);
    instr_valid_i = 1'b0;
    step();
    check("idle_valid", {31'b0, id_valid_o}, 32'd0);

    // Stall with writeback snoop
    instr_valid_i = 1'b1; instr_i = I_SW; pc_i = 32'h200; id_ready_i = 1'b0;
    #1;
    check("sw_rs2a", {27'b0, rf_rs2_addr_o}, 32'd5);
    step();
    check("sw_valid", {31'b0, id_valid_o}, 32'd1);
    check("sw_op", {28'b0, id_op_o}, 32'd3);
    check("sw_imm", id_imm_o, 32'hFFFFFFFC);
    check("sw_we", {31'b0, id_we_rd_o}, 32'd0);
    check("sw_f3", {29'b0, id_funct3_o}, 32'd2);
    check("sw_rs1", id_rs1_o, 32'h22);
    check("sw_rs2", id_rs2_o, 32'h55);
    instr_i = I_ADD; pc_i = 32'h204;
    #1;
    check("stall_ready", {31'b0, instr_ready_o}, 32'd0);
    check("stall_re", {31'b0, rf_re_o}, 32'd0);
    step();
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd5; wb_data_i = 32'hDEAD;
    #1;
    check("stall2_rs2", id_rs2_o, 32'h55);
    step();
    wb_we_i = 1'b0;
    check("stall3_rs2", id_rs2_o, 32'hDEAD);
    check("stall3_pc", id_pc_o, 32'h200);
    check("stall3_imm", id_imm_o, 32'hFFFFFFFC);
    wb_write(5'd0, 32'hBAD);
    check("wbx0_rs1", id_rs1_o, 32'h22);
    check("wbx0_rs2", id_rs2_o, 32'hDEAD);
    wb_write(5'd9, 32'hBAD);
    check("wbx9_rs1", id_rs1_o, 32'h22);
    check("wbx9_rs2", id_rs2_o, 32'hDEAD);
    wb_write(5'd2, 32'h2222);
    check("wbx2_rs1", id_rs1_o, 32'h2222);
    wb_write(5'd5, 32'hBEEF);
    check("later_wins_rs2", id_rs2_o, 32'hBEEF);
    check("held_pc", id_pc_o, 32'h200);
    instr_valid_i = 1'b0; id_ready_i = 1'b1;
    step();
    check("xfer_valid", {31'b0, id_valid_o}, 32'd0);

    // Flush while stalled
    instr_valid_i = 1'b1; instr_i = I_ADD35; pc_i = 32'h300; id_ready_i = 1'b0;
    step();
    check("fl_pkt_rs1", id_rs1_o, 32'h2222);
    check("fl_pkt_rs2", id_rs2_o, 32'hBEEF);
    instr_valid_i = 1'b0;
    wb_write(5'd5, 32'h1234);
    check("fl_snoop_rs2", id_rs2_o, 32'h1234);
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd2; wb_data_i = 32'h9999;
    flush_i = 1'b1; instr_valid_i = 1'b1; instr_i = I_ADD35;
    #1;
    check("flush_ready", {31'b0, instr_ready_o}, 32'd0);
    step();
    flush_i = 1'b0; wb_we_i = 1'b0;
    check("flush_valid", {31'b0, id_valid_o}, 32'd0);
    instr_i = I_ADD22; pc_i = 32'h304;
    step();
    check("postfl_valid", {31'b0, id_valid_o}, 32'd1);
    check("postfl_rs1", id_rs1_o, 32'h9999);
    check("postfl_rs2", id_rs2_o, 32'h9999);
    check("postfl_pc", id_pc_o, 32'h304);
    instr_valid_i = 1'b0; id_ready_i = 1'b1;
    step();

    // Illegal / branch / lui
    instr_valid_i = 1'b1; instr_i = 32'h0; pc_i = 32'h400;
    step();
    check("zero_op", {28'b0, id_op_o}, 32'd15);
    check("zero_ill", {31'b0, id_illegal_o}, 32'd1);
    check("zero_we", {31'b0, id_we_rd_o}, 32'd0);
    instr_i = I_MUL;
    #1;
    check("mul_rs2a", {27'b0, rf_rs2_addr_o}, 32'd3);
    step();
    check("mul_op", {28'b0, id_op_o}, 32'd15);
    check("mul_ill", {31'b0, id_illegal_o}, 32'd1);
    check("mul_we", {31'b0, id_we_rd_o}, 32'd0);
    instr_i = I_BEQ;
    step();
    check("beq_op", {28'b0, id_op_o}, 32'd4);
    check("beq_imm", id_imm_o, 32'hFFFFFFF8);
    check("beq_ill", {31'b0, id_illegal_o}, 32'd0);
    check("beq_we", {31'b0, id_we_rd_o}, 32'd0);
    instr_i = I_LUI;
    #1;
    check("lui_rs1a", {27'b0, rf_rs1_addr_o}, 32'd0);
    step();
    check("lui_op", {28'b0, id_op_o}, 32'd7);
    check("lui_imm", id_imm_o, 32'h12345000);
    check("lui_rd", {27'b0, id_rd_addr_o}, 32'd7);
    check("lui_we", {31'b0, id_we_rd_o}, 32'd1);
    instr_valid_i = 1'b0;
    step();

    // Asynchronous reset mid-stall
    instr_valid_i = 1'b1; instr_i = I_ADDI; pc_i = 32'h500; id_ready_i = 1'b0;
    step();
    check("pre_arst_valid", {31'b0, id_valid_o}, 32'd1);
    instr_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, id_valid_o}, 32'd0);
    check("arst_op", {28'b0, id_op_o}, 32'd0);
    check("arst_imm", id_imm_o, 32'd0);
    check("arst_we", {31'b0, id_we_rd_o}, 32'd0);
    check("arst_rd", {27'b0, id_rd_addr_o}, 32'd0);
    check("arst_rs1", id_rs1_o, 32'd0);
    step();
    rst = 1'b0;
    instr_valid_i = 1'b1; instr_i = I_ADDI; pc_i = 32'h600; id_ready_i = 1'b1;
    step();
    check("rel_valid", {31'b0, id_valid_o}, 32'd1);
    check("rel_op", {28'b0, id_op_o}, 32'd1);
    check("rel_imm", id_imm_o, 32'd5);
    check("rel_we", {31'b0, id_we_rd_o}, 32'd1);
    check("rel_pc", id_pc_o, 32'h600);
    instr_valid_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
